// File: rtl/yuv2rgb.sv
// yuv2rgb: converts unsigned Y plus signed U/V to clamped unsigned RGB. enable=0 passes y/u/v straight through.
// Latency: 3 cycles, one pixel per clock. Sideband (dvi, dtypei, meta_datai) is delayed by the same amount.
// Backpressure: none. A pixel is accepted every cycle, and data registers update whether or not dvi is set.
// Ports: clk, reset (synchronous, active-high); enable, dvi, dtypei, y, u, v, meta_datai in;
//        dvo, dtypeo, r, g, b, meta_datao out.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module yuv2rgb #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0]  y,
  input  logic [PIXEL_WIDTH-1:0]  u,
  input  logic [PIXEL_WIDTH-1:0]  v,
  input  logic [15:0]             meta_datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0]  r,
  output logic [PIXEL_WIDTH-1:0]  g,
  output logic [PIXEL_WIDTH-1:0]  b,
  output logic [15:0]             meta_datao
);

  localparam int PW    = PIXEL_WIDTH;
  localparam int ACC_W = PW + 12;   // signed accumulator width
  localparam int SH_W  = ACC_W - 8; // width after the >>> 8
  localparam int DTW   = `DTYPE_WIDTH;

  localparam logic signed [10:0] K_Y  = 11'sd298;
  localparam logic signed [10:0] K_RV = 11'sd409;
  localparam logic signed [10:0] K_GU = 11'sd100;
  localparam logic signed [10:0] K_GV = 11'sd208;
  localparam logic signed [10:0] K_BU = 11'sd516;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(128);

  function automatic logic signed [ACC_W-1:0] kext(input logic signed [10:0] k);
    return {{(ACC_W-11){k[10]}}, k};
  endfunction

  // A negative sum clamps to 0. Any bit set above the pixel range saturates to all ones.
  function automatic logic [PW-1:0] clamp(input logic signed [SH_W-1:0] x);
    if (x[SH_W-1])             return '0;
    else if (|x[SH_W-2:PW])    return '1;
    else                       return x[PW-1:0];
  endfunction

  // ---------------- S1: products ----------------
  logic signed [ACC_W-1:0] y_ext, u_ext, v_ext;
  logic signed [ACC_W-1:0] p_y_d, p_rv_d, p_gu_d, p_gv_d, p_bu_d;
  logic signed [ACC_W-1:0] p_y_q, p_rv_q, p_gu_q, p_gv_q, p_bu_q;
  logic [PW-1:0]           y1_q, u1_q, v1_q;
  logic                    en1_q, dv1_q;
  logic [DTW-1:0]          dt1_q;
  logic [15:0]             md1_q;

  always_comb begin
    y_ext  = {{(ACC_W-PW){1'b0}}, y};      // Y is unsigned
    u_ext  = {{(ACC_W-PW){u[PW-1]}}, u};   // U is signed
    v_ext  = {{(ACC_W-PW){v[PW-1]}}, v};   // V is signed
    p_y_d  = y_ext * kext(K_Y);
    p_rv_d = v_ext * kext(K_RV);
    p_gu_d = u_ext * kext(K_GU);
    p_gv_d = v_ext * kext(K_GV);
    p_bu_d = u_ext * kext(K_BU);
  end

  // ---------------- S2: rounded, shifted sums ----------------
  logic signed [ACC_W-1:0] r_acc, g_acc, b_acc;
  logic signed [SH_W-1:0]  r_sh_d, g_sh_d, b_sh_d;
  logic signed [SH_W-1:0]  r_sh_q, g_sh_q, b_sh_q;
  logic [PW-1:0]           y2_q, u2_q, v2_q;
  logic                    en2_q, dv2_q;
  logic [DTW-1:0]          dt2_q;
  logic [15:0]             md2_q;

  always_comb begin
    r_acc  = p_y_q + p_rv_q + RND;
    g_acc  = p_y_q - p_gu_q - p_gv_q + RND;
    b_acc  = p_y_q + p_bu_q + RND;
    // The arithmetic shift floors negative sums. The clamp in S3 sends them to 0.
    r_sh_d = SH_W'(r_acc >>> 8);
    g_sh_d = SH_W'(g_acc >>> 8);
    b_sh_d = SH_W'(b_acc >>> 8);
  end

  // ---------------- S3: clamp or bypass ----------------
  logic [PW-1:0]  r_d, g_d, b_d;
  logic [PW-1:0]  r_q, g_q, b_q;
  logic           dv3_q;
  logic [DTW-1:0] dt3_q;
  logic [15:0]    md3_q;

  always_comb begin
    r_d = en2_q ? clamp(r_sh_q) : y2_q;
    g_d = en2_q ? clamp(g_sh_q) : u2_q;
    b_d = en2_q ? clamp(b_sh_q) : v2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_y_q  <= '0; p_rv_q <= '0; p_gu_q <= '0; p_gv_q <= '0; p_bu_q <= '0;
      y1_q   <= '0; u1_q   <= '0; v1_q   <= '0;
      en1_q  <= 1'b0; dv1_q <= 1'b0; dt1_q <= '0; md1_q <= '0;
      r_sh_q <= '0; g_sh_q <= '0; b_sh_q <= '0;
      y2_q   <= '0; u2_q   <= '0; v2_q   <= '0;
      en2_q  <= 1'b0; dv2_q <= 1'b0; dt2_q <= '0; md2_q <= '0;
      r_q    <= '0; g_q    <= '0; b_q    <= '0;
      dv3_q  <= 1'b0; dt3_q <= '0; md3_q <= '0;
    end else begin
      p_y_q  <= p_y_d;  p_rv_q <= p_rv_d; p_gu_q <= p_gu_d;
      p_gv_q <= p_gv_d; p_bu_q <= p_bu_d;
      y1_q   <= y;      u1_q   <= u;      v1_q   <= v;
      en1_q  <= enable; dv1_q  <= dvi;    dt1_q  <= dtypei; md1_q <= meta_datai;

      r_sh_q <= r_sh_d; g_sh_q <= g_sh_d; b_sh_q <= b_sh_d;
      y2_q   <= y1_q;   u2_q   <= u1_q;   v2_q   <= v1_q;
      en2_q  <= en1_q;  dv2_q  <= dv1_q;  dt2_q  <= dt1_q;  md2_q <= md1_q;

      r_q    <= r_d;    g_q    <= g_d;    b_q    <= b_d;
      dv3_q  <= dv2_q;  dt3_q  <= dt2_q;  md3_q  <= md2_q;
    end
  end

  assign dvo        = dv3_q;
  assign dtypeo     = dt3_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign meta_datao = md3_q;

endmodule

// File: tb/tb_yuv2rgb.sv
// tb_yuv2rgb: scoreboard bench for yuv2rgb.
// The driver pushes an expected pixel and its due cycle when it issues the input.
// The monitor pops and compares on every dvo.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module tb_yuv2rgb;

  localparam int DTW = `DTYPE_WIDTH;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           dvi = 1'b0;
  logic [DTW-1:0] dtypei = '0;
  logic [7:0]     y = '0, u = '0, v = '0;
  logic [15:0]    meta_datai = '0;
  logic           dvo;
  logic [DTW-1:0] dtypeo;
  logic [7:0]     r, g, b;
  logic [15:0]    meta_datao;

  yuv2rgb #(.PIXEL_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .y(y), .u(u), .v(v), .meta_datai(meta_datai),
    .dvo(dvo), .dtypeo(dtypeo), .r(r), .g(g), .b(b), .meta_datao(meta_datao)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int             due;
    logic [DTW-1:0] dt;
    logic [15:0]    md;
    logic [7:0]     r, g, b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   seq = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] clamp8(input int x);
    if (x < 0)   return 8'h00;
    if (x > 255) return 8'hFF;
    return x[7:0];
  endfunction

  function automatic logic [23:0] model(input logic en, input logic [7:0] yy, uu, vv);
    int yi, ui, vi, rr, gg, bb;
    if (!en) return {yy, uu, vv};
    yi = int'(yy);
    ui = int'($signed(uu));
    vi = int'($signed(vv));
    rr = (298*yi + 409*vi + 128) >>> 8;
    gg = (298*yi - 100*ui - 208*vi + 128) >>> 8;
    bb = (298*yi + 516*ui + 128) >>> 8;
    return {clamp8(rr), clamp8(gg), clamp8(bb)};
  endfunction

  // Apply inputs now. They are captured at the next rising edge and due 3 cycles after that edge.
  task automatic drive(input logic d, input logic en, input logic [7:0] yy, uu, vv,
                       input logic [7:0] er, eg, eb);
    exp_t e;
    reset      = 1'b0;
    dvi        = d;
    enable     = en;
    y          = yy;
    u          = uu;
    v          = vv;
    dtypei     = DTW'(seq);
    meta_datai = seq[15:0];
    seq++;
    if (d) begin
      e.due = cyc + 3;
      e.dt  = dtypei;
      e.md  = meta_datai;
      e.r   = er;
      e.g   = eg;
      e.b   = eb;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic d, input logic en, input logic [7:0] yy, uu, vv,
                      input logic [7:0] er, eg, eb);
    @(posedge clk);
    #1;
    drive(d, en, yy, uu, vv, er, eg, eb);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dvo"},    {31'd0, dvo}, 32'd0);
    chk({tag, "_r"},      {24'd0, r}, 32'd0);
    chk({tag, "_g"},      {24'd0, g}, 32'd0);
    chk({tag, "_b"},      {24'd0, b}, 32'd0);
    chk({tag, "_dtypeo"}, 32'(dtypeo), 32'd0);
    chk({tag, "_meta"},   {16'd0, meta_datao}, 32'd0);
  endtask

  // Monitor: samples on the falling edge, away from the register updates.
  always @(negedge clk) begin : mon
    exp_t e;
    if (dvo === 1'b1) begin
      if (sb.size() == 0) begin
        chk("dvo_unexpected", {31'd0, dvo}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("r", {24'd0, r}, {24'd0, e.r});
        chk("g", {24'd0, g}, {24'd0, e.g});
        chk("b", {24'd0, b}, {24'd0, e.b});
        chk("dtypeo", 32'(dtypeo), 32'(e.dt));
        chk("meta_datao", {16'd0, meta_datao}, {16'd0, e.md});
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("dvo_missing", {31'd0, dvo}, 32'd1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [23:0] m;
    logic        d, en;
    logic [7:0]  yy, uu, vv;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");

    // Conversion, enable = 1, hand-computed expectations
    send(1, 1, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0);
    send(1, 1, 8'd219, 8'd0,   8'd0,   8'd255, 8'd255, 8'd255);
    send(1, 1, 8'd100, 8'd0,   8'd0,   8'd116, 8'd116, 8'd116);
    send(1, 1, 8'd66,  8'hDA,  8'h70,  8'd255, 8'd1,   8'd0);
    send(1, 1, 8'd255, 8'd0,   8'd127, 8'd255, 8'd194, 8'd255);
    send(1, 1, 8'd0,   8'h80,  8'h80,  8'd0,   8'd154, 8'd0);
    send(0, 1, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0);

    // Bypass, then enable toggled every cycle
    send(1, 0, 8'h12,  8'h34,  8'h56,  8'h12,  8'h34,  8'h56);
    send(0, 0, 8'h00,  8'h00,  8'h00,  8'h00,  8'h00,  8'h00);
    send(1, 1, 8'd100, 8'd0,   8'd0,   8'd116, 8'd116, 8'd116);
    send(1, 0, 8'hAB,  8'hCD,  8'hEF,  8'hAB,  8'hCD,  8'hEF);
    send(1, 1, 8'd219, 8'd0,   8'd0,   8'd255, 8'd255, 8'd255);
    send(1, 0, 8'd66,  8'hDA,  8'h70,  8'd66,  8'hDA,  8'h70);
    send(1, 1, 8'd66,  8'hDA,  8'h70,  8'd255, 8'd1,   8'd0);

    // Random dvi pattern, incrementing sideband, reference model for pixels
    for (int i = 0; i < 40; i++) begin
      d  = 1'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      yy = 8'($urandom);
      uu = 8'($urandom);
      vv = 8'($urandom);
      m  = model(en, yy, uu, vv);
      send(d, en, yy, uu, vv, m[23:16], m[15:8], m[7:0]);
    end

    // Reset mid-stream with a full pipeline
    send(1, 1, 8'd100, 8'd0, 8'd0, 8'd116, 8'd116, 8'd116);
    send(1, 1, 8'd219, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255);
    send(1, 1, 8'd0,   8'd0, 8'd0, 8'd0,   8'd0,   8'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    dvi   = 1'b1;
    // In-flight pixels due at or after the reset edge are discarded.
    while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
    @(posedge clk);
    #1;
    check_zero_outputs("midreset");
    drive(1, 1, 8'd66, 8'hDA, 8'h70, 8'd255, 8'd1, 8'd0);

    // Drain the pipeline
    repeat (6) send(0, 1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yuv2rgb.md
# yuv2rgb

Pipelined converter from the imager's internal YUV format back to RGB, the inverse of the RGB-to-YUV stage. Input Y is unsigned with no +16 offset. Input U and V are two's-complement signed with no +128 offset. The block sits downstream of YUV-domain processing (sharpening, saturation, etc.) and feeds RGB consumers. Sideband signals (dv, dtype, meta data) travel through the pipeline aligned with their pixel.

## Interface
- PIXEL_WIDTH, 8, bits per channel on every input and output pixel bus.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = convert; 0 = bypass (y/u/v copied to r/g/b unchanged). Sampled per pixel.
- dvi  input  1  input data valid.
- dtypei  input  `DTYPE_WIDTH  input data type; passed through untouched.
- y  input  PIXEL_WIDTH  luma, unsigned, 0..2^PW-1.
- u  input  PIXEL_WIDTH  Cb, signed two's complement.
- v  input  PIXEL_WIDTH  Cr, signed two's complement.
- meta_datai  input  16  sideband; passed through untouched.
- dvo  output  1  output data valid.
- dtypeo  output  `DTYPE_WIDTH  delayed dtypei.
- r, g, b  output  PIXEL_WIDTH each  unsigned RGB result.
- meta_datao  output  16  delayed meta_datai.

## Operation
- Equations use 8-bit fractional coefficients (value/256), unsigned Y, signed U/V:
  - R = (298·Y + 409·V + 128) >>> 8
  - G = (298·Y − 100·U − 208·V + 128) >>> 8
  - B = (298·Y + 516·U + 128) >>> 8
- Coefficients are 11-bit signed constants.
- Products and sums use a signed accumulator of PIXEL_WIDTH+12 bits. Y is zero-extended and U/V are sign-extended before multiplying.
- >>> 8 is an arithmetic shift, so negative values floor. The +128 term is the rounding constant.
- Clamp each channel to [0, 2^PW−1]: negative → 0, above max → all ones, otherwise the low PW bits.
- Pipeline stages:
  - S1 registers the five products (298Y, 409V, 100U, 208V, 516U), the raw y/u/v, enable, dvi, dtypei and meta_datai.
  - S2 registers the three rounded, shifted sums and carries the raw y/u/v and sideband.
  - S3 registers the clamped results, or the raw y/u/v when the carried enable = 0, onto r/g/b along with the sideband outputs.
- enable travels with each pixel, so toggling enable mid-stream switches mode exactly at the pixel where it changed.
- There is no backpressure; the block accepts one pixel per cycle unconditionally.
- Data registers update every cycle regardless of dvi. Downstream must qualify r/g/b with dvo; their values while dvo = 0 are don't-care.
- dtype and meta are never interpreted.

## Timing
- Latency is exactly 3 cycles from dvi/y/u/v/dtypei/meta_datai/enable to dvo/r/g/b/dtypeo/meta_datao.
- Throughput is 1 pixel/clk. Any dvi pattern, including back-to-back, reappears unchanged 3 cycles later.
- Reset values: dvo = 0, dtypeo = 0, meta_datao = 0, r = g = b = 0, and all internal pipeline registers = 0.
- Reset mid-stream:
  - The cycle after reset is sampled high, all outputs read 0 and in-flight pixels are discarded.
  - The first input valid on the cycle reset deasserts appears 3 cycles later.
- Reset has priority over all other activity.

## Test plan
- Conversion with PW = 8, enable = 1:
  - (Y,U,V) = (0,0,0) → (R,G,B) = (0,0,0).
  - (219,0,0) → (255,255,255).
  - (100,0,0) → (116,116,116).
- Round-trip of pure red: (66, −38 = 0xDA, 112 = 0x70) → (255,1,0).
- Clamping:
  - (255,0,127) → (255,194,255), with R and B clamped high.
  - (0,−128,−128) → (0,154,0), with R and B clamped low.
- Bypass: enable = 0, (0x12,0x34,0x56) → r = 0x12, g = 0x34, b = 0x56 exactly 3 cycles later. Toggle enable every cycle and confirm each output pixel follows its own enable.
- Sideband alignment: random dvi pattern with dtypei/meta_datai set to an incrementing count.
  - dvo, dtypeo and meta_datao reproduce the input sequence delayed by 3.
  - r/g/b match a reference model on every dvo = 1 cycle.
- Reset: fill the pipeline with valid pixels, then assert reset for 1 cycle.
  - Next cycle: dvo = 0 and all outputs are 0.
  - A pixel presented on the first post-reset cycle appears 3 cycles later with the correct value.
